// File: rtl/alu_flag_unit.sv
// NZVC flag register and branch-condition evaluator sitting behind the 64-bit ALU.
// Resolves B.cond (with optional same-cycle flag bypass), CBZ and CBNZ into take_branch.
module alu_flag_unit #(
    parameter bit         FORWARD     = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry_out,
    input  logic       set_flags,
    input  logic [3:0] cond,
    input  logic       br_cond_en,
    input  logic       cbz_en,
    input  logic       cbnz_en,
    output logic       take_branch,
    output logic [3:0] flags,
    output logic       flags_valid,
    output logic       err
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    logic [3:0] flags_q, flags_d;
    logic       flags_valid_q, flags_valid_d;
    logic       err_q, err_d;

    logic [3:0] alu_flags;
    logic [3:0] eff_flags;
    logic       e_n, e_z, e_v, e_c;
    logic       cond_met;
    logic       illegal;

    assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

    // Bypass lets a flag-setting op and a dependent B.cond resolve in the same cycle.
    assign eff_flags = (FORWARD && set_flags) ? alu_flags : flags_q;
    assign {e_n, e_z, e_v, e_c} = eff_flags;

    assign illegal = (br_cond_en & cbz_en) | (br_cond_en & cbnz_en) | (cbz_en & cbnz_en);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cond_met = 1'b1;
        case (cond)
            COND_EQ: cond_met = e_z;
            COND_NE: cond_met = ~e_z;
            COND_HS: cond_met = e_c;
            COND_LO: cond_met = ~e_c;
            COND_MI: cond_met = e_n;
            COND_PL: cond_met = ~e_n;
            COND_VS: cond_met = e_v;
            COND_VC: cond_met = ~e_v;
            COND_HI: cond_met = e_c & ~e_z;
            COND_LS: cond_met = ~e_c | e_z;
            COND_GE: cond_met = (e_n == e_v);
            COND_LT: cond_met = (e_n != e_v);
            COND_GT: cond_met = ~e_z & (e_n == e_v);
            COND_LE: cond_met = e_z | (e_n != e_v);
            default: cond_met = 1'b1;
        endcase
    end

    // CBZ/CBNZ test the live ALU zero output; they never touch the flag register.
    always_comb begin
        take_branch = 1'b0;
        if (!illegal) begin
            if (br_cond_en)   take_branch = cond_met;
            else if (cbz_en)  take_branch = alu_zero;
            else if (cbnz_en) take_branch = ~alu_zero;
        end
    end

    always_comb begin
        flags_d       = set_flags ? alu_flags : flags_q;
        flags_valid_d = flags_valid_q | set_flags;
        err_d         = err_q | illegal;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q       <= RESET_FLAGS;
            flags_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            err_q         <= err_d;
        end
    end

    assign flags       = flags_q;
    assign flags_valid = flags_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: a forwarding instance and a non-forwarding
// instance share stimulus; a condition-code table plus hand-written corner sequences.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic       set_flags;
    logic [3:0] cond;
    logic       br_cond_en, cbz_en, cbnz_en;

    logic       take_f, take_n;
    logic [3:0] flags_f, flags_n;
    logic       valid_f, valid_n;
    logic       err_f, err_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_flag_unit #(.FORWARD(1'b1), .RESET_FLAGS(4'b0000)) dut_fwd (
        .clk(clk), .reset(reset),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .set_flags(set_flags), .cond(cond),
        .br_cond_en(br_cond_en), .cbz_en(cbz_en), .cbnz_en(cbnz_en),
        .take_branch(take_f), .flags(flags_f), .flags_valid(valid_f), .err(err_f)
    );

    alu_flag_unit #(.FORWARD(1'b0), .RESET_FLAGS(4'b0000)) dut_nofwd (
        .clk(clk), .reset(reset),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .set_flags(set_flags), .cond(cond),
        .br_cond_en(br_cond_en), .cbz_en(cbz_en), .cbnz_en(cbnz_en),
        .take_branch(take_n), .flags(flags_n), .flags_valid(valid_n), .err(err_n)
    );

    typedef struct packed {
        logic [3:0] nzvc;
        logic [3:0] cond;
        logic       exp_take;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sf, input logic [3:0] nzvc, input logic [3:0] c,
                         input logic br, input logic z_en, input logic nz_en);
        set_flags = sf;
        {alu_negative, alu_zero, alu_overflow, alu_carry_out} = nzvc;
        cond       = c;
        br_cond_en = br;
        cbz_en     = z_en;
        cbnz_en    = nz_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] z_conds [4];
        logic       z_exp   [4];

        // {N,Z,V,C}, cond, expected take_branch on those flags
        vecs.push_back('{4'b0100, 4'b0000, 1'b1});  // EQ, Z=1
        vecs.push_back('{4'b0000, 4'b0000, 1'b0});  // EQ, Z=0
        vecs.push_back('{4'b0000, 4'b0001, 1'b1});  // NE
        vecs.push_back('{4'b0001, 4'b0010, 1'b1});  // HS
        vecs.push_back('{4'b0000, 4'b0011, 1'b1});  // LO
        vecs.push_back('{4'b1000, 4'b0100, 1'b1});  // MI
        vecs.push_back('{4'b1000, 4'b0101, 1'b0});  // PL
        vecs.push_back('{4'b0010, 4'b0110, 1'b1});  // VS
        vecs.push_back('{4'b0010, 4'b0111, 1'b0});  // VC
        vecs.push_back('{4'b0001, 4'b1000, 1'b1});  // HI, C & !Z
        vecs.push_back('{4'b0101, 4'b1000, 1'b0});  // HI, Z set
        vecs.push_back('{4'b0101, 4'b1001, 1'b1});  // LS, Z set
        vecs.push_back('{4'b0001, 4'b1001, 1'b0});  // LS, C & !Z
        vecs.push_back('{4'b1010, 4'b1010, 1'b1});  // GE, N==V==1
        vecs.push_back('{4'b1000, 4'b1010, 1'b0});  // GE, N!=V
        vecs.push_back('{4'b1000, 4'b1011, 1'b1});  // LT
        vecs.push_back('{4'b0000, 4'b1100, 1'b1});  // GT
        vecs.push_back('{4'b0100, 4'b1100, 1'b0});  // GT, Z set
        vecs.push_back('{4'b1010, 4'b1100, 1'b1});  // GT, N==V
        vecs.push_back('{4'b0010, 4'b1101, 1'b1});  // LE, N!=V
        vecs.push_back('{4'b0000, 4'b1101, 1'b0});  // LE
        vecs.push_back('{4'b0000, 4'b1110, 1'b1});  // AL
        vecs.push_back('{4'b0000, 4'b1111, 1'b1});  // NV

        // Reset state, no enables
        reset = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_flags_f", flags_f, 4'b0000);
        check("rst_flags_n", flags_n, 4'b0000);
        check("rst_valid", {valid_f, valid_n}, 2'b00);
        check("rst_err", {err_f, err_n}, 2'b00);
        check("rst_take", {take_f, take_n}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("no_x", {3'b000, $isunknown({take_f, flags_f, valid_f, err_f, take_n, flags_n, valid_n, err_n})}, 4'b0000);

        // NE against reset flags
        drive(1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        #1;
        check("ne_reset_take", {take_f, take_n}, 2'b11);
        check("ne_reset_valid", {valid_f, valid_n}, 2'b00);

        // SUBS 0x8000..0 - 1: N0 Z0 V1 C1, GE in the same cycle
        drive(1'b1, 4'b0011, 4'b1010, 1'b1, 1'b0, 1'b0);
        #1;
        check("ge_fwd_take", take_f, 1'b0);
        check("ge_nofwd_take", take_n, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 1'b0);
        #1;
        check("subs_flags_f", flags_f, 4'b0011);
        check("subs_flags_n", flags_n, 4'b0011);
        check("subs_valid", {valid_f, valid_n}, 2'b11);
        check("lt_take", {take_f, take_n}, 2'b11);

        // SUBS x - x: N0 Z1 V0 C1, then EQ/HI/LS/LE on registered flags
        drive(1'b1, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
        tick();
        z_conds = '{4'b0000, 4'b1000, 4'b1001, 4'b1101};
        z_exp   = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0000, z_conds[i], 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("zc_take_f_%0d", i), take_f, z_exp[i]);
            check($sformatf("zc_take_n_%0d", i), take_n, z_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
            tick();
            check($sformatf("hold_flags_%0d", i), flags_f, 4'b0101);
            check($sformatf("hold_flags_n_%0d", i), flags_n, 4'b0101);
        end

        // CBZ/CBNZ follow live alu_zero, not the registered Z
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
        #1;
        check("cbz_z1", {take_f, take_n}, 2'b11);
        drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1);
        #1;
        check("cbnz_z1", {take_f, take_n}, 2'b00);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        #1;
        check("cbnz_z0", {take_f, take_n}, 2'b11);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        #1;
        check("cbz_z0", {take_f, take_n}, 2'b00);
        tick();
        check("cb_flags_kept", flags_f, 4'b0011);
        check("cb_flags_kept_n", flags_n, 4'b0011);

        // Condition table: forwarded decision, then registered decision next cycle
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].nzvc, vecs[i].cond, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("tbl_fwd_%0d", i), take_f, vecs[i].exp_take);
            @(posedge clk);
            #1;
            set_flags = 1'b0;
            #1;
            check($sformatf("tbl_flags_%0d", i), flags_f, vecs[i].nzvc);
            check($sformatf("tbl_flags_n_%0d", i), flags_n, vecs[i].nzvc);
            check($sformatf("tbl_reg_f_%0d", i), take_f, vecs[i].exp_take);
            check($sformatf("tbl_reg_n_%0d", i), take_n, vecs[i].exp_take);
        end

        // Forward vs no-forward with registered Z=0 and incoming Z=1
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
        #1;
        check("eq_fwd_same", take_f, 1'b1);
        check("eq_nofwd_same", take_n, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        #1;
        check("eq_next_cycle", {take_f, take_n}, 2'b11);

        // Illegal request: B.cond + CBZ, with a flag update in the same cycle
        drive(1'b1, 4'b1000, 4'b1110, 1'b1, 1'b1, 1'b0);
        #1;
        check("illegal_take", {take_f, take_n}, 2'b00);
        check("illegal_err_pre", {err_f, err_n}, 2'b00);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("illegal_err", {err_f, err_n}, 2'b11);
        check("illegal_flags", flags_f, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("err_sticky_%0d", i), {err_f, err_n}, 2'b11);
        end
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_err", {err_f, err_n}, 2'b00);
        check("mid_rst_flags", flags_f, 4'b0000);
        check("mid_rst_valid", {valid_f, valid_n}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        #1;
        check("post_rst_eq", {take_f, take_n}, 2'b00);
        drive(1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        #1;
        check("post_rst_ne", {take_f, take_n}, 2'b11);

        // CBZ + CBNZ together is also illegal
        drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
        #1;
        check("illegal2_take", {take_f, take_n}, 2'b00);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("illegal2_err", {err_f, err_n}, 2'b11);
        check("illegal2_flags", flags_f, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
